// File: rtl/amiq_fifo_pkg.sv
// Purpose: shared constants, pointer type and helper functions for the
//          amiq_fifo_sync FIFO and its storage sub-module.
// Contents: default width/depth, level/pointer width helpers, pointer
//           increment with explicit wrap at DEPTH-1 (any depth, not only 2^k).
package amiq_fifo_pkg;

  localparam int unsigned N_DEFAULT     = 8;
  localparam int unsigned DEPTH_DEFAULT = 16;

  // Widest pointer the helpers handle; callers cast down to their own width.
  localparam int unsigned PTR_W_MAX = 16;
  typedef logic [PTR_W_MAX-1:0] ptr_t;

  // Width of the occupancy counter: must hold 0..DEPTH inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a memory address / pointer.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Advance a pointer, wrapping DEPTH-1 -> 0 by compare rather than overflow.
  function automatic ptr_t ptr_inc(input ptr_t p, input int unsigned depth);
    return (p == ptr_t'(depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/amiq_fifo_sync_if.sv
// Purpose: write/read handshake bundle of the synchronous FIFO.
// Signals: wr_en/wr_data/rd_en/err_clr driven by the agent (master);
//          full/almost_full/empty/almost_empty/level/rd_data/rd_valid/
//          overflow/underflow driven by the FIFO (slave).
interface amiq_fifo_sync_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 16
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic          wr_en;
  logic [N-1:0]  wr_data;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [N-1:0]  rd_data;
  logic          rd_valid;
  logic          empty;
  logic          almost_empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;
  logic          err_clr;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/amiq_fifo_mem.sv
// Purpose: DEPTH x N storage, one write port and one registered read port.
// Ports:  clk, rst_n (sync, active-low, clears only the read register);
//         i_we/i_waddr/i_wdata write port; i_re/i_raddr read request;
//         o_rdata registered read data, holds when i_re=0.
module amiq_fifo_mem
  import amiq_fifo_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_we,
  input  logic [ptr_w(DEPTH)-1:0]   i_waddr,
  input  logic [N-1:0]              i_wdata,
  input  logic                      i_re,
  input  logic [ptr_w(DEPTH)-1:0]   i_raddr,
  output logic [N-1:0]              o_rdata
);

  logic [N-1:0] r_mem [DEPTH];
  logic [N-1:0] r_rdata;

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register; the FIFO never reads and writes the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/amiq_fifo_sync.sv
// Purpose: single-clock FIFO of any depth with full backpressure, registered
//          read port (rd_valid pulse), fill level, almost flags and sticky
//          overflow/underflow error flags.
// Ports:  clk, rst_n (sync, active-low); s_if (slave modport) carrying the
//         write side, read side, status flags, level and error signals.
module amiq_fifo_sync
  import amiq_fifo_pkg::*;
#(
  parameter int unsigned N        = N_DEFAULT,
  parameter int unsigned DEPTH    = DEPTH_DEFAULT,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  amiq_fifo_sync_if.slave  s_if
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_rd_valid;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [N-1:0]  w_rdata;

  // Flags decode from the registered level, so acceptance uses pre-edge state.
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_wr_acc = s_if.wr_en & ~w_full;
  assign w_rd_acc = s_if.rd_en & ~w_empty;

  // Pointers, level, read-valid pulse and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= PW'(ptr_inc(ptr_t'(r_wr_ptr), DEPTH));
      end
      if (w_rd_acc) begin
        r_rd_ptr <= PW'(ptr_inc(ptr_t'(r_rd_ptr), DEPTH));
      end

      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      r_rd_valid <= w_rd_acc;

      // A new error event in the clear cycle wins over the clear.
      if (s_if.wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (s_if.err_clr) begin
        r_overflow <= 1'b0;
      end

      if (s_if.rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (s_if.err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  amiq_fifo_mem #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (s_if.wr_data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign s_if.full         = w_full;
  assign s_if.empty        = w_empty;
  assign s_if.almost_full  = (r_level >= LW'(AF_LEVEL));
  assign s_if.almost_empty = (r_level <= LW'(AE_LEVEL));
  assign s_if.level        = r_level;
  assign s_if.rd_data      = w_rdata;
  assign s_if.rd_valid     = r_rd_valid;
  assign s_if.overflow     = r_overflow;
  assign s_if.underflow    = r_underflow;

endmodule

// File: doc/amiq_fifo_sync.md
Name: amiq_fifo_sync

Overview:
Parametrised single-clock synchronous FIFO and the DUT driven by the fifo write and read agents.
- Generalises the write-side protocol (wr_en validating an N-bit wr_data) with any depth, not just powers of two.
- Adds write-side full backpressure, a registered read port with rd_valid, a fill level, and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags with a synchronous clear.

Parameters:
- N, 8, data width in bits (1..N legal, N>=1).
- DEPTH, 16, number of entries (>=2; need not be a power of two).
- AF_LEVEL, DEPTH-2, almost_full asserted when level >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserted when level <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  producer asserts to indicate valid wr_data.
- wr_data  in  N  write data, validated by wr_en.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AF_LEVEL.
- rd_en  in  1  consumer read request.
- rd_data  out  N  read data, valid when rd_valid=1.
- rd_valid  out  1  one-cycle pulse marking rd_data valid.
- empty  out  1  level == 0.
- almost_empty  out  1  level <= AE_LEVEL.
- level  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- err_clr  in  1  clears overflow/underflow.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wr_ptr=0, rd_ptr=0, level=0.
  - empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>=1).
  - rd_valid=0, rd_data=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents; outputs take reset values at that edge.
- Write accept: wr_en & ~full.
  - mem[wr_ptr] <= wr_data.
  - wr_ptr advances; wraps DEPTH-1 -> 0 (explicit compare, not modulo 2^k).
- Read accept: rd_en & ~empty.
  - rd_data <= mem[rd_ptr] and rd_valid=1 on the next cycle (1-cycle latency).
  - rd_ptr advances with the same wrap rule.
  - rd_data holds its last value when rd_valid=0.
- Level:
  - +1 on write-only accept; -1 on read-only accept.
  - Unchanged when both are accepted or neither is.
  - Never exceeds DEPTH, never below 0.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from the registered level and reflect the state after the last edge.
- Acceptance is judged on pre-edge flags only:
  - wr_en while full: write dropped, even with a simultaneous accepted rd_en; overflow<=1.
  - rd_en while empty: read rejected, even with a simultaneous wr_en; rd_valid=0 next cycle; underflow<=1.
  - Simultaneous accepted read and write at any 0<level<DEPTH: both proceed and level holds.
  - Read-after-write: the read returns the oldest entry, never the same-cycle write data.
- err_clr: clears overflow/underflow on the next edge. If a new error event occurs in the same cycle, the set wins.
- Ordering: strict FIFO; data integrity is preserved across pointer wrap.
- No X on any output after reset, regardless of wr_data/rd_en X while not enabled.

Decomposition:
- Package amiq_fifo_pkg:
  - default constants: `N default, DEPTH default.
  - level width function: clog2(DEPTH+1).
  - pointer-increment-with-wrap function.
  - typedef for the pointer type.
- Sub-module amiq_fifo_mem: DEPTH x N storage with one write port (we, waddr, wdata) and one synchronous read port (re, raddr, rdata registered).
- Top amiq_fifo_sync holds pointers, level, flags and error logic.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, almost_empty=1, full=0, level=0, rd_valid=0, overflow=0, underflow=0.
- N=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1: write 0x11,0x22,0x33,0x44 on consecutive cycles.
  - level goes 1,2,3,4.
  - almost_full rises when level=3; full=1 at 4.
  - almost_empty drops when level=2.
- With full=1, drive wr_en=1, wr_data=0x55 together with rd_en=1:
  - 0x55 dropped, overflow=1, level=3.
  - Next cycle rd_data=0x11, rd_valid=1.
  - Drain the rest -> 0x22,0x33,0x44.
- DEPTH=5 (non power of 2): stream 12 words 0x00..0x0B with write and read every cycle after the first write.
  - Reads return 0x00..0x0B in order.
  - level stays at 1.
  - Pointers wrap 4->0 twice without corruption.
- Empty FIFO, rd_en=1 with wr_en=1, wr_data=0xA5:
  - underflow=1, rd_valid=0 next cycle, level=1.
  - A following rd_en returns 0xA5.
  - err_clr=1 for one cycle -> overflow=0, underflow=0.
- Mid-stream reset: load 3 words, assert rst_n=0 for 1 cycle -> level=0, empty=1, rd_valid=0; a subsequent write/read of 0x7E returns 0x7E.
